// File: rtl/p2s_ctrl_if.sv
// p2s_ctrl_if: start/data request and serial-side outputs of p2s_ctrl.
// Master drives the request; slave is the sequencer.
interface p2s_ctrl_if #(
  parameter int WIDTH = 64
);

  logic             start;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             done;
  logic             s_clk;
  logic             s_out;
  logic             latch;

  modport master (
    output start,
    output data,
    input  busy,
    input  done,
    input  s_clk,
    input  s_out,
    input  latch
  );

  modport slave (
    input  start,
    input  data,
    output busy,
    output done,
    output s_clk,
    output s_out,
    output latch
  );

endinterface

// File: rtl/p2s_ctrl.sv
// p2s_ctrl: MSB-first serialiser with divided s_clk, latch strobe, done pulse.
// Define P2S_QUEUE_EN to add a one-deep pending word for back-to-back sends.
module p2s_ctrl #(
  parameter int WIDTH = 64,
  parameter int DIV   = 1
) (
  input  logic      clk,
  input  logic      rst,
  p2s_ctrl_if.slave p2s
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [CW-1:0] NBIT = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bcnt_q, bcnt_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             hi_q, hi_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic sclk_q, sclk_d;
  logic sout_q, sout_d;
  logic latch_q, latch_d;

`ifdef P2S_QUEUE_EN
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;
`endif

  logic last_ph;
  assign last_ph = (phase_q == PMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      phase_q <= '0;
      hi_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sout_q  <= 1'b0;
      latch_q <= 1'b0;
`ifdef P2S_QUEUE_EN
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      sout_q  <= sout_d;
      latch_q <= latch_d;
`ifdef P2S_QUEUE_EN
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    hi_d    = hi_q;
`ifdef P2S_QUEUE_EN
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    if (state_q != IDLE && p2s.start && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_data_d  = p2s.data;
    end
`endif
    unique case (state_q)
      IDLE: begin
        if (p2s.start) begin
          state_d = SHIFT;
          shreg_d = p2s.data;
          bcnt_d  = NBIT;
          phase_d = '0;
          hi_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (!last_ph) begin
          phase_d = phase_q + PW'(1);
        end else begin
          phase_d = '0;
          hi_d    = ~hi_q;
          // bit retires at the end of its high phase
          if (hi_q) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            bcnt_d  = bcnt_q - CW'(1);
            if (bcnt_q == CW'(1)) begin
              state_d = LATCH;
            end
          end
        end
      end
      LATCH: begin
        if (!last_ph) begin
          phase_d = phase_q + PW'(1);
        end else begin
          phase_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef P2S_QUEUE_EN
        // a start seen here with an empty buffer goes straight out
        if (pend_valid_q) begin
          state_d      = SHIFT;
          shreg_d      = pend_data_q;
          bcnt_d       = NBIT;
          phase_d      = '0;
          hi_d         = 1'b0;
          pend_valid_d = 1'b0;
        end else if (p2s.start) begin
          state_d      = SHIFT;
          shreg_d      = p2s.data;
          bcnt_d       = NBIT;
          phase_d      = '0;
          hi_d         = 1'b0;
          pend_valid_d = 1'b0;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    latch_d = (state_d == LATCH);
    sclk_d  = (state_d == SHIFT) && hi_d;
    sout_d  = (state_d == SHIFT) && shreg_d[WIDTH-1];
  end

  assign p2s.busy  = busy_q;
  assign p2s.done  = done_q;
  assign p2s.s_clk = sclk_q;
  assign p2s.s_out = sout_q;
  assign p2s.latch = latch_q;

endmodule

// File: doc/p2s_ctrl.md
# p2s_ctrl

Sequencer for the serial-in/parallel-out 64-bit display shift register. It accepts a parallel word on a start pulse and shifts it out MSB-first on a divided serial clock. It then pulses a latch strobe and signals completion. The block sits between the display-data source and the shift register, driving that register's clock-enable/serial-input pair, so that after one transfer the register's parallel output equals the captured word.

## Interface
- WIDTH, 64: bits per transfer; ≥2.
- DIV, 1: clk cycles per half period of s_clk; ≥1.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  transfer request, sampled on rising clk.
- data  input  WIDTH  word to send; sampled only in the cycle start is accepted.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle completion pulse.
- s_clk  output  1  serial shift clock; downstream register shifts on its rising edge.
- s_out  output  1  serial data.
- latch  output  1  strobe after the last bit.

## Operation
- States: IDLE, SHIFT, LATCH, DONE.
- IDLE
  - Outputs: s_clk=0, s_out=0, latch=0, busy=0, done=0.
  - start=1: load shreg←data, bit counter←WIDTH, phase counter←0, go to SHIFT.
- SHIFT, per bit:
  - s_out = shreg[WIDTH-1] throughout the bit.
  - s_clk=0 for DIV cycles, then s_clk=1 for DIV cycles.
  - On the last high-phase cycle: shreg shifts left (zero in), counter decrements.
  - When the counter reaches 0, go to LATCH.
- LATCH: s_clk=0, s_out=0, latch=1 for DIV cycles, then go to DONE.
- DONE: done=1 for exactly one cycle, busy still 1, then go to IDLE (or restart, see Configuration).
- Bit order is MSB first, so the downstream register (shift-left, serial in at LSB) holds data exactly after WIDTH rising s_clk edges.
- start while busy: ignored (default build).
- Counters: bit counter is $clog2(WIDTH+1) bits; phase counter is $clog2(DIV) bits (min 1). Both wrap only under state control, never free-run.
- Reset (async, any state): state=IDLE, shreg=0, all counters 0, all outputs 0 immediately. A transfer cut by reset is abandoned; latch and done are not asserted for it.

## Timing
- Cycle 0 = rising edge where start is sampled in IDLE.
- busy=1 from cycle 1 through the DONE cycle inclusive.
- SHIFT occupies cycles 1 .. 2·DIV·WIDTH.
- Bit k (k=0 is MSB) has s_clk high on cycles 2·DIV·k+DIV+1 .. 2·DIV·k+2·DIV.
- LATCH occupies the next DIV cycles; done is asserted at cycle 2·DIV·WIDTH+DIV+1.
- Default build (WIDTH=64, DIV=1):
  - Rising s_clk edges at cycles 2,4,…,128.
  - latch at cycle 129.
  - done at cycle 130.
  - busy=0 at cycle 131.
- All outputs are registered; no combinational path from inputs to outputs.
- data may change freely after cycle 0.

## Configuration
- P2S_QUEUE_EN defined: adds a one-deep pending buffer (pend_valid, pend_data).
  - start while busy and pend_valid=0: captures data and sets pend_valid.
  - start while busy and pend_valid=1: ignored (first pending word kept).
  - In DONE with pend_valid=1: next cycle is SHIFT with shreg←pend_data, pend_valid cleared.
  - Back-to-back case: busy stays 1 and done still pulses once per transfer.
  - start in the DONE cycle counts as "while busy".
  - Reset clears pend_valid.
- P2S_QUEUE_EN undefined: no buffer; start is honoured only in IDLE.

## Test plan
- Reset then idle, start=0 for 20 cycles -> all outputs 0, no s_clk edges.
- WIDTH=64, DIV=1, data=64'hF0F0_1234_ABCD_0001, with a behavioural shift-left register on s_clk/s_out -> 64 rising s_clk edges, latch at cycle 129, done at cycle 130, register equals 64'hF0F0_1234_ABCD_0001.
- DIV=3, WIDTH=8, data=8'hA5 -> s_clk period 6 cycles, s_out bits 1,0,1,0,0,1,0,1, done at cycle 52.
- start pulsed at cycle 40 with a different data word (default build) -> ignored; one done only; register holds the first word.
- rst asserted at cycle 50 of a DIV=1 transfer, then released, then start with data=64'h1 -> outputs 0 immediately; no latch/done for the aborted word; new transfer completes with the register equal to 64'h1.
- P2S_QUEUE_EN: start A at cycle 0, start B at cycle 10, start C at cycle 20 -> A then B sent back-to-back, busy continuous, done at cycles 130 and 260, C dropped.
